data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Byte-addressed, little-endian data memory for the single-cycle core's MEM stage, with a valid/ready request port, registered one-cycle read response, access-fault reporting and memory-mapped UART registers. UART transmit is buffered in a small FIFO with a proper valid/ready handshake toward the UART, so back-to-back stores to the TX register do not lose characters. Sits between the core's load/store path and the UART TX/RX blocks.

## Interface
- XLEN, 32, data/address width (32 only in this revision)
- DEPTH_BYTES, 1024, RAM size in bytes, power of two
- TX_FIFO_DEPTH, 4, TX buffer entries, power of two, >= 2
- UART_RX_DATA, 'h650, RX data register address
- UART_RX_STAT, 'h660, RX status address (bit0 = rx valid)
- UART_TX_DATA, 'h680, TX data register address
- UART_TX_STAT, 'h684, TX status address (bit0 = fifo empty, bit1 = fifo full)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  access request
- req_ready  out  1  request may be accepted
- req_we  in  1  1 = store, 0 = load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- req_funct3  in  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load data (0 for stores/faults)
- rsp_fault  out  1  access fault, valid with rsp_valid
- uart_tx_data  out  8  FIFO head byte
- uart_tx_valid  out  1  FIFO non-empty
- uart_tx_ready  in  1  UART accepts byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte pending
- uart_rx_pop  out  1  one-cycle pulse: RX byte consumed

## Operation
- Accept when req_valid && req_ready. req_ready = 0 only when req addresses UART_TX_DATA with req_we=1 and FIFO full; otherwise 1.
- RAM load: bytes addr..addr+n-1 assembled little-endian; B/H sign-extend, BU/HU zero-extend, W direct.
- RAM store: writes n bytes (1/2/4) from req_wdata low bytes.
- Fault (no write, rdata 0): funct3 in {3,6,7}; store with funct3 4/5; RAM access with addr+n-1 >= DEPTH_BYTES not hitting an MMIO address.
- MMIO (exact address match, any size): store TX_DATA pushes wdata[7:0]; load TX_STAT returns status zero-extended; load RX_DATA returns uart_rx_data zero-extended and pulses uart_rx_pop if uart_rx_valid; load RX_STAT returns {0, uart_rx_valid}. Stores to status/RX addresses ignored, no fault; loads of TX_DATA return 0.
- FIFO: pop on uart_tx_valid && uart_tx_ready; simultaneous push and pop keep count; pointers wrap modulo TX_FIFO_DEPTH.
- RAM contents not reset.

## Timing
- Response latency 1: accept at edge N, rsp_valid/rsp_rdata/rsp_fault valid for the cycle after edge N; back-to-back requests give back-to-back responses.
- Store takes effect at the accepting edge; a load accepted the next cycle sees it.
- Pushed byte visible on uart_tx_valid/uart_tx_data the cycle after acceptance; FIFO full reaches req_ready the same cycle the count updates.
- uart_rx_pop asserted together with rsp_valid of the RX_DATA load.
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_fault 0, uart_tx_valid 0, uart_tx_data 0, uart_rx_pop 0, FIFO empty. Reset mid-operation drops the in-flight response and FIFO contents.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: H at odd address or W with addr[1:0] != 0 faults (no write, rdata 0).
- Undefined: misaligned RAM accesses complete byte-wise at any address (only range check applies).

## Structure
- Package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), default MMIO addresses, TX status bit indices.
- Sub-module sync_fifo (WIDTH=8, DEPTH=TX_FIFO_DEPTH, count, full/empty flags) for the TX buffer.

## Test plan
- SW 'hDEADBEEF at 'h10, then LB/LBU/LH/LHU/LW at 'h10/'h13 -> 'hFFFFFFEF, 'h000000EF, 'hFFFFBEEF, 'h0000BEEF, 'hDEADBEEF; LB 'h13 -> 'hFFFFFFDE.
- Five SB to 'h680 with uart_tx_ready=0, depth 4 -> four accepted, fifth stalls req_ready=0; raise uart_tx_ready -> bytes drain in order, fifth accepted one cycle after first pop.
- uart_rx_valid=1, uart_rx_data='h41; LW 'h660 -> 1; LBU 'h650 -> 'h41 with uart_rx_pop pulse in same cycle as rsp_valid.
- LW at 'h3FE (DEPTH_BYTES 1024) -> rsp_fault=1, rdata 0; SW there -> fault, RAM unchanged; funct3=3 -> fault.
- LW 'h11 -> with DMEM_MISALIGN_TRAP_EN fault; without, bytes 'h11..'h14 returned.
- Assert rst with 3 bytes queued and a load in flight -> no rsp_valid, uart_tx_valid 0 next cycle, TX_STAT reads 'h1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data memory controller: load/store size codes,
// default UART register addresses and TX status bit positions.
// No logic; imported by data_mem_ctrl.
package dmem_pkg;

    // funct3 size/sign encodings of the load/store instructions
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Default memory-mapped UART register addresses
    localparam logic [31:0] DEF_UART_RX_DATA = 32'h0000_0650;
    localparam logic [31:0] DEF_UART_RX_STAT = 32'h0000_0660;
    localparam logic [31:0] DEF_UART_TX_DATA = 32'h0000_0680;
    localparam logic [31:0] DEF_UART_TX_STAT = 32'h0000_0684;

    // Bit positions inside the TX status word
    localparam int TX_STAT_EMPTY_BIT = 0;
    localparam int TX_STAT_FULL_BIT  = 1;

    // Access size minus one (0, 1 or 3 bytes beyond the base address)
    function automatic logic [1:0] size_m1(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    size_m1 = 2'd0;
            2'd1:    size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
    endfunction

    // Encodings with no defined meaning, plus unsigned variants used on stores
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        f3_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and full/empty flags.
// Latency: a pushed entry appears on rd_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so stale storage never leaks out
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because count gates the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data RAM plus memory-mapped UART TX/RX registers.
// Latency: one cycle from accepting edge to rsp_valid; stores commit at the accepting edge.
// Backpressure: req_ready drops only for a TX_DATA store while the TX FIFO is full.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned H/W RAM accesses fault instead of completing byte-wise.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter int              DEPTH_BYTES   = 1024,
    parameter int              TX_FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] UART_RX_DATA  = DEF_UART_RX_DATA,
    parameter logic [XLEN-1:0] UART_RX_STAT  = DEF_UART_RX_STAT,
    parameter logic [XLEN-1:0] UART_TX_DATA  = DEF_UART_TX_DATA,
    parameter logic [XLEN-1:0] UART_TX_STAT  = DEF_UART_TX_STAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic [7:0]      uart_tx_data,
    output logic            uart_tx_valid,
    input  logic            uart_tx_ready,
    input  logic [7:0]      uart_rx_data,
    input  logic            uart_rx_valid,
    output logic            uart_rx_pop
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            hit_rx_data, hit_rx_stat, hit_tx_data, hit_tx_stat, mmio_hit;
    logic [1:0]      sz_m1;
    logic [XLEN:0]   last_addr;
    logic            f3_fault, range_fault, misalign_fault, fault;
    logic            accept, ram_we, tx_push, tx_pop, rx_pop_nxt;
    logic [AW-1:0]   base;
    logic [7:0]      rd_b [4];
    logic [XLEN-1:0] ram_rdata, mmio_rdata, rdata_nxt;
    logic [CW-1:0]   tx_count;
    logic            tx_full, tx_empty;

    // Address decode: MMIO registers are exact-address matches of any size
    assign hit_rx_data = (req_addr == UART_RX_DATA);
    assign hit_rx_stat = (req_addr == UART_RX_STAT);
    assign hit_tx_data = (req_addr == UART_TX_DATA);
    assign hit_tx_stat = (req_addr == UART_TX_STAT);
    assign mmio_hit    = hit_rx_data || hit_rx_stat || hit_tx_data || hit_tx_stat;

    // Range check on the last byte touched, one bit wider so high addresses cannot wrap
    assign sz_m1       = size_m1(req_funct3);
    assign last_addr   = {1'b0, req_addr} + {{(XLEN-1){1'b0}}, sz_m1};
    assign range_fault = (last_addr >= (XLEN+1)'(DEPTH_BYTES));
    assign f3_fault    = f3_illegal(req_funct3, req_we);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_fault = ((sz_m1 == 2'd1) && req_addr[0]) ||
                            ((sz_m1 == 2'd3) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_fault = 1'b0;
`endif

    assign fault = f3_fault || (!mmio_hit && (range_fault || misalign_fault));

    // Handshake: only a TX_DATA store can stall, and only on a full FIFO
    assign req_ready  = !(hit_tx_data && req_we && tx_full);
    assign accept     = req_valid && req_ready;
    assign ram_we     = accept && req_we && !fault && !mmio_hit;
    assign tx_push    = accept && req_we && hit_tx_data && !f3_fault;
    assign tx_pop     = uart_tx_valid && uart_tx_ready;
    assign rx_pop_nxt = accept && !req_we && hit_rx_data && uart_rx_valid && !f3_fault;
    assign base       = req_addr[AW-1:0];

    // Byte-wise RAM write of the low 1/2/4 bytes of the store data
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(sz_m1)) begin
                    mem[base + AW'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Gather the four bytes starting at the request address (index wraps harmlessly on faults)
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_b[i] = mem[base + AW'(i)];
        end
    end

    // Little-endian assembly with sign or zero extension per funct3
    always_comb begin
        ram_rdata = '0;
        case (req_funct3)
            F3_B:    ram_rdata = {{(XLEN-8){rd_b[0][7]}}, rd_b[0]};
            F3_BU:   ram_rdata = {{(XLEN-8){1'b0}}, rd_b[0]};
            F3_H:    ram_rdata = {{(XLEN-16){rd_b[1][7]}}, rd_b[1], rd_b[0]};
            F3_HU:   ram_rdata = {{(XLEN-16){1'b0}}, rd_b[1], rd_b[0]};
            F3_W:    ram_rdata = XLEN'({rd_b[3], rd_b[2], rd_b[1], rd_b[0]});
            default: ram_rdata = '0;
        endcase
    end

    // MMIO read mux; TX_DATA reads back as zero
    always_comb begin
        mmio_rdata = '0;
        if (hit_tx_stat) begin
            mmio_rdata[TX_STAT_EMPTY_BIT] = tx_empty;
            mmio_rdata[TX_STAT_FULL_BIT]  = tx_full;
        end else if (hit_rx_data) begin
            mmio_rdata = XLEN'(uart_rx_data);
        end else if (hit_rx_stat) begin
            mmio_rdata = XLEN'(uart_rx_valid);
        end
    end

    // Response data is zero for stores and faulted accesses
    always_comb begin
        rdata_nxt = '0;
        if (!fault && !req_we) begin
            rdata_nxt = mmio_hit ? mmio_rdata : ram_rdata;
        end
    end

    // Registered response; reset drops any in-flight response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_fault   <= 1'b0;
            uart_rx_pop <= 1'b0;
        end else begin
            rsp_valid   <= accept;
            rsp_rdata   <= accept ? rdata_nxt : '0;
            rsp_fault   <= accept && fault;
            uart_rx_pop <= rx_pop_nxt;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .wr_data (req_wdata[7:0]),
        .pop     (tx_pop),
        .rd_data (uart_tx_data),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign uart_tx_valid = (tx_count != '0);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stimulus pushes expected responses and TX bytes
// into queues; independent monitors pop and compare whenever the DUT presents them.
// Optional build DMEM_MISALIGN_TRAP_EN selects the trapping expectations.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_pop;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        pop;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    string       name_q [$];
    logic [7:0]  tx_q [$];
    exp_t        e_mon;
    string       n_mon;
    logic [7:0]  tx_exp;

    data_mem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_funct3    (req_funct3),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_fault     (rsp_fault),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_pop   (uart_rx_pop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every rsp_valid must match the oldest expectation, one cycle after acceptance
    always @(negedge clk) begin
        if (rsp_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: got rdata=%h fault=%b, expected no response", rsp_rdata, rsp_fault);
            end else begin
                e_mon = exp_q.pop_front();
                n_mon = name_q.pop_front();
                if (rsp_rdata !== e_mon.rdata || rsp_fault !== e_mon.fault ||
                    uart_rx_pop !== e_mon.pop || cyc != e_mon.cyc) begin
                    fails++;
                    $display("FAIL %s: got rdata=%h fault=%b pop=%b cyc=%0d, expected rdata=%h fault=%b pop=%b cyc=%0d",
                             n_mon, rsp_rdata, rsp_fault, uart_rx_pop, cyc,
                             e_mon.rdata, e_mon.fault, e_mon.pop, e_mon.cyc);
                end
            end
        end else if (uart_rx_pop) begin
            tests++;
            fails++;
            $display("FAIL stray_rx_pop: got uart_rx_pop=1 without rsp_valid, expected 0");
        end
    end

    // TX monitor: each byte handed to the UART must be the next expected byte
    always @(negedge clk) begin
        if (!rst && uart_tx_valid && uart_tx_ready) begin
            tests++;
            if (tx_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tx: got byte %h, expected none", uart_tx_data);
            end else begin
                tx_exp = tx_q.pop_front();
                if (uart_tx_data !== tx_exp) begin
                    fails++;
                    $display("FAIL tx_order: got byte %h, expected %h", uart_tx_data, tx_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input string name, input logic [31:0] rd,
                                     input logic flt, input logic pop);
        exp_t e;
        e.rdata = rd;
        e.fault = flt;
        e.pop   = pop;
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
        name_q.push_back(name);
    endfunction

    // Drive one request (called just after a rising edge); wait for ready, bounded
    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rd, input logic exp_flt, input logic exp_pop);
        int waited = 0;
        bit ok = 1'b1;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 100) begin
                tests++;
                fails++;
                $display("FAIL %s_timeout: got req_ready=0 for %0d cycles, expected 1", name, waited);
                ok = 1'b0;
                break;
            end
        end
        if (ok) push_exp(name, exp_rd, exp_flt, exp_pop);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        req_funct3    = 3'd0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 32'h0);
        check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        check("rst_rx_pop", {31'b0, uart_rx_pop}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // RAM loads of every size/sign
        issue("sw_10",  1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 0, 0);
        issue("lb_10",  0, 32'h10, 32'h0, 3'd0, 32'hFFFFFFEF, 0, 0);
        issue("lbu_10", 0, 32'h10, 32'h0, 3'd4, 32'h000000EF, 0, 0);
        issue("lh_10",  0, 32'h10, 32'h0, 3'd1, 32'hFFFFBEEF, 0, 0);
        issue("lhu_10", 0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 0, 0);
        issue("lw_10",  0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 0, 0);
        issue("lb_13",  0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 0, 0);
        issue("lbu_13", 0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 0, 0);
        issue("lh_12",  0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 0, 0);
        issue("sw_14",  1, 32'h14, 32'h11223344, 3'd2, 32'h0, 0, 0);
        // Store immediately followed by a load of the same word
        issue("sb_11",  1, 32'h11, 32'hFFFFFF55, 3'd0, 32'h0, 0, 0);
        issue("lw_10b", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0, 0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        issue("lw_11_mis", 0, 32'h11, 32'h0, 3'd2, 32'h0, 1, 0);
        issue("lh_11_mis", 0, 32'h11, 32'h0, 3'd1, 32'h0, 1, 0);
        issue("sh_13_mis", 1, 32'h13, 32'h9999, 3'd1, 32'h0, 1, 0);
`else
        issue("lw_11_mis", 0, 32'h11, 32'h0, 3'd2, 32'h44DEAD55, 0, 0);
        issue("lh_11_mis", 0, 32'h11, 32'h0, 3'd1, 32'hFFFFAD55, 0, 0);
`endif

        // Range and funct3 faults
        issue("sw_3fc",    1, 32'h3FC, 32'hCAFEF00D, 3'd2, 32'h0, 0, 0);
        issue("lw_3fe",    0, 32'h3FE, 32'h0, 3'd2, 32'h0, 1, 0);
        issue("sw_3fe",    1, 32'h3FE, 32'h12345678, 3'd2, 32'h0, 1, 0);
        issue("lw_3fc",    0, 32'h3FC, 32'h0, 3'd2, 32'hCAFEF00D, 0, 0);
        issue("lb_3ff",    0, 32'h3FF, 32'h0, 3'd0, 32'hFFFFFFCA, 0, 0);
        issue("lh_3ff",    0, 32'h3FF, 32'h0, 3'd1, 32'h0, 1, 0);
        issue("lw_400",    0, 32'h400, 32'h0, 3'd2, 32'h0, 1, 0);
        issue("ld_f3_3",   0, 32'h10, 32'h0, 3'd3, 32'h0, 1, 0);
        issue("ld_f3_6",   0, 32'h10, 32'h0, 3'd6, 32'h0, 1, 0);
        issue("ld_f3_7",   0, 32'h10, 32'h0, 3'd7, 32'h0, 1, 0);
        issue("st_f3_4",   1, 32'h10, 32'h0, 3'd4, 32'h0, 1, 0);
        issue("lw_10_kept", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 0, 0);

        // UART RX registers
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h41;
        issue("rx_stat_1",  0, 32'h660, 32'h0, 3'd2, 32'h1, 0, 0);
        issue("rx_data_41", 0, 32'h650, 32'h0, 3'd4, 32'h41, 0, 1);
        uart_rx_valid = 1'b0;
        issue("rx_data_nov", 0, 32'h650, 32'h0, 3'd2, 32'h41, 0, 0);
        issue("rx_stat_0",  0, 32'h660, 32'h0, 3'd2, 32'h0, 0, 0);
        issue("st_rx_stat", 1, 32'h660, 32'hFF, 3'd2, 32'h0, 0, 0);
        issue("ld_tx_data", 0, 32'h680, 32'h0, 3'd2, 32'h0, 0, 0);
        issue("tx_stat_e",  0, 32'h684, 32'h0, 3'd2, 32'h1, 0, 0);

        // TX FIFO fills with the UART stalled
        for (int i = 0; i < 4; i++) begin
            issue("sb_tx", 1, 32'h680, 32'hA1 + i, 3'd0, 32'h0, 0, 0);
            tx_q.push_back(8'hA1 + 8'(i));
        end
        issue("tx_stat_full", 0, 32'h684, 32'h0, 3'd2, 32'h2, 0, 0);
        @(negedge clk);
        check("tx_valid_full", {31'b0, uart_tx_valid}, 32'h1);
        check("tx_head_a1", {24'b0, uart_tx_data}, 32'hA1);

        // Fifth byte stalls until the first pop frees a slot
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h680;
        req_wdata  = 32'hA5;
        req_funct3 = 3'd0;
        @(negedge clk);
        check("stall_ready0", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1 uart_tx_ready = 1'b1;
        @(negedge clk);
        check("stall_ready0_b", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_pop", {31'b0, req_ready}, 32'h1);
        if (req_ready) begin
            push_exp("sb_tx5", 32'h0, 1'b0, 1'b0);
            tx_q.push_back(8'hA5);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("tx_drained_valid", {31'b0, uart_tx_valid}, 32'h0);
        issue("tx_stat_e2", 0, 32'h684, 32'h0, 3'd2, 32'h1, 0, 0);

        // Reset with three bytes queued and a load in flight
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue("sb_tx_drop", 1, 32'h680, 32'hB0 + i, 3'd0, 32'h0, 0, 0);
        end
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_mid_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        issue("tx_stat_after_rst", 0, 32'h684, 32'h0, 3'd2, 32'h1, 0, 0);
        uart_tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_fifo_empty", {31'b0, uart_tx_valid}, 32'h0);

        repeat (3) @(posedge clk);
        check("rsp_queue_empty", exp_q.size(), 32'h0);
        check("tx_queue_empty", tx_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
